// File: rtl/truth_table_extractor_if.sv
// Probe/sample bus between the truth-table sweeper and the function under test.
interface truth_table_extractor_if #(
    parameter int unsigned N_INPUTS = 5
) ();
    localparam int unsigned MASK_W = 1 << N_INPUTS;

    logic                  start;
    logic                  f_in;
    logic [MASK_W-1:0]     expected_mask;
    logic [N_INPUTS-1:0]   probe;
    logic                  busy;
    logic                  done;
    logic [MASK_W-1:0]     minterm_mask;
    logic [N_INPUTS:0]     minterm_count;
    logic                  match;

    modport master (
        output start, f_in, expected_mask,
        input  probe, busy, done, minterm_mask, minterm_count, match
    );

    modport slave (
        input  start, f_in, expected_mask,
        output probe, busy, done, minterm_mask, minterm_count, match
    );
endinterface

// File: rtl/truth_table_extractor.sv
// Sweeps every input combination of a combinational function, records its
// minterm mask and popcount, and compares the mask against a reference.
module truth_table_extractor #(
    parameter int unsigned N_INPUTS      = 5,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    truth_table_extractor_if.slave  bus
);
    localparam int unsigned MASK_W = 1 << N_INPUTS;
    localparam int unsigned CNT_W  = N_INPUTS + 1;
    localparam int unsigned SET_W  = 4;

    localparam logic [N_INPUTS-1:0] PROBE_LAST  = '1;
    localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state_q,  state_d;
    logic [N_INPUTS-1:0] probe_q,  probe_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [MASK_W-1:0]   mask_q,   mask_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic                match_q,  match_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            probe_q  <= '0;
            settle_q <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            match_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            probe_q  <= probe_d;
            settle_q <= settle_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            match_q  <= match_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        probe_d  = probe_q;
        settle_d = settle_q;
        mask_d   = mask_q;
        count_d  = count_q;
        match_d  = match_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_SETTLE;
                    probe_d  = '0;
                    settle_d = '0;
                    mask_d   = '0;
                    count_d  = '0;
                    match_d  = 1'b0;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + SET_W'(1);
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                mask_d[probe_q] = bus.f_in;
                count_d         = count_q + CNT_W'(bus.f_in);
                // Probe stops at all-ones rather than wrapping back to zero
                if (probe_q == PROBE_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_SETTLE;
                    probe_d  = probe_q + N_INPUTS'(1);
                    settle_d = '0;
                end
            end
            S_DONE: begin
                match_d = (mask_q == bus.expected_mask);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign bus.probe         = probe_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.minterm_mask  = mask_q;
    assign bus.minterm_count = count_q;
    assign bus.match         = match_q;
endmodule

// File: doc/truth_table_extractor.md
TRUTH_TABLE_EXTRACTOR -- requirements
Module: truth_table_extractor

Interface
REQ-001 Parameter N_INPUTS, default 5: number of function inputs probed; legal range 1..6.
REQ-002 Parameter SETTLE_CYCLES, default 2: cycles the probe vector is held before f_in is sampled; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-006 f_in  input  1  output of the combinational function under test.
REQ-007 expected_mask  input  2**N_INPUTS  reference minterm mask; sampled only in DONE.
REQ-008 probe  output  N_INPUTS  input vector driven to the function, MSB = first variable (A), LSB = last (E).
REQ-009 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-010 done  output  1  one-cycle pulse when the sweep completes.
REQ-011 minterm_mask  output  2**N_INPUTS  bit i = f_in sampled while probe == i.
REQ-012 minterm_count  output  N_INPUTS+1  number of set bits in minterm_mask.
REQ-013 match  output  1  minterm_mask == expected_mask; updated on the done cycle, held otherwise.

Function
REQ-014 FSM states IDLE, SETTLE, SAMPLE, DONE; encoding is free.
REQ-015 IDLE: busy=0, probe holds its last value; start=1 -> SETTLE next cycle with probe=0, settle counter=0, minterm_mask=0, minterm_count=0, match=0.
REQ-016 SETTLE: settle counter increments each cycle; when the counter equals SETTLE_CYCLES-1 -> SAMPLE next cycle.
REQ-017 SAMPLE (single cycle): minterm_mask[probe] <= f_in; minterm_count increments by f_in.
REQ-018 SAMPLE with probe != 2**N_INPUTS-1 -> SETTLE with probe+1 and settle counter cleared.
REQ-019 SAMPLE with probe == 2**N_INPUTS-1 -> DONE; probe does not wrap and holds its all-ones value.
REQ-020 Each minterm costs exactly SETTLE_CYCLES+1 cycles; done asserts exactly (2**N_INPUTS)*(SETTLE_CYCLES+1)+1 cycles after the cycle in which start=1 was accepted in IDLE.
REQ-021 DONE lasts exactly one cycle: done=1, busy=1; match is computed there against the final mask (including the last sample); next state is IDLE.
REQ-022 start while busy (SETTLE, SAMPLE, DONE) is ignored with no effect on the sweep in progress.
REQ-023 start in the IDLE cycle immediately following DONE starts a new sweep normally.
REQ-024 minterm_mask, minterm_count and match hold their values in IDLE until the next accepted start.
REQ-025 f_in is sampled only in SAMPLE; f_in changes in any other state have no effect.
REQ-026 minterm_count never overflows: its width holds 2**N_INPUTS.

Reset
REQ-027 rst=1 at a clock edge -> state IDLE, probe=0, busy=0, done=0, minterm_mask=0, minterm_count=0, match=0, settle counter=0.
REQ-028 rst takes priority over start and over every state transition, including mid-sweep and in DONE; done is never asserted on the cycle after rst.
REQ-029 After rst deasserts, the block stays in IDLE until a new start.

Verification
REQ-030 f_in tied 1, defaults, start pulse -> done exactly 97 cycles after start; mask=0xFFFFFFFF, count=32; expected_mask=0xFFFFFFFF -> match=1.
REQ-031 f_in = probe[0] (combinational loopback), defaults -> mask=0xAAAAAAAA, count=16; expected_mask=0x55555555 -> match=0.
REQ-032 f_in = 1 only when probe==5'b10110, SETTLE_CYCLES=1 -> mask=0x00400000, count=1, done exactly 65 cycles after start.
REQ-033 start re-pulsed at cycles 10 and 50 of a sweep -> no restart; done timing and mask identical to an unperturbed run.
REQ-034 rst asserted for 1 cycle at cycle 40 of a sweep -> all outputs zero next cycle, no done pulse; a later start gives a full correct sweep.
REQ-035 N_INPUTS=3, f_in = probe[2]&probe[1] -> mask=0xC0, count=2; probe walks 0..7 and holds 7 after DONE.
